// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   uart_arb_state_t           - arbiter FSM state encoding
//   UART_ARB_GAP_CYCLES_DEF    - default idle clocks after each byte
//   UART_ARB_START_TIMEOUT_DEF - default clocks to wait for the UART to go busy
//   ASCII_CR / ASCII_LF        - line-ending bytes used by message generators
package uart_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_START     = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_DONE = 3'd3,
        ARB_GAP       = 3'd4
    } uart_arb_state_t;

    localparam int UART_ARB_GAP_CYCLES_DEF    = 0;
    localparam int UART_ARB_START_TIMEOUT_DEF = 16;

    localparam logic [7:0] ASCII_CR = 8'd13;
    localparam logic [7:0] ASCII_LF = 8'd10;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req - request vector (N bits)
//   ptr - highest-priority index; search starts here and wraps N-1 -> 0
//   gnt - one-hot winner, all zero when no request is set
//   idx - binary index of the winner, 0 when no request is set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester at or
    // after ptr is the last one written and therefore wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        sum  = '0;
        cand = '0;
        for (int off = N - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (IW + 1)'(off);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources.
// Round-robin arbitration of valid/ready byte requests, one-cycle transmit
// strobe per accepted byte, completion tracking via is_transmitting, optional
// idle gap after each byte and a start timeout if the UART never goes busy.
//
// Handshake: a byte moves on a clock edge where req_valid[i] & req_ready[i];
// req_ready is combinational, one-hot, and only offered in IDLE while the UART
// is not busy. Sources hold valid/data until accepted; dropping valid first
// simply withdraws the request.
//
// Optional build macro UART_TX_ARB_LOCK_EN: accepting a byte with req_last=0
// locks arbitration to that source until its req_last=1 byte is accepted, so
// multi-byte messages stay contiguous. Without it req_last is ignored.
//
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   req_valid/ready  - per-source handshake (NUM_REQ bits)
//   req_data         - source i byte at [8i+7:8i]
//   req_last         - last byte of a message (lock build only)
//   transmit         - one-cycle start strobe to the UART
//   tx_byte          - registered byte, held until the next accept
//   is_transmitting  - UART busy flag
//   grant_id         - source index of the current/last byte
//   busy             - high whenever the FSM is not IDLE
//   start_err        - one-cycle pulse when the UART failed to start
//   state_dbg        - current FSM state
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = UART_ARB_GAP_CYCLES_DEF,
    parameter int START_TIMEOUT = UART_ARB_START_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       transmit,
    output logic [7:0]                 tx_byte,
    input  logic                       is_transmitting,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       start_err,
    output logic [2:0]                 state_dbg
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    uart_arb_state_t state_q, state_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] win_gnt;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      rr_next;
    logic               can_accept;
    logic               accept;
    logic               start_err_c;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;

    // While locked only the owning source (the last granted one) competes.
    always_comb begin
        arb_req = req_valid;
        if (lock_q) begin
            arb_req = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q);
        end
    end
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;
    assign arb_req         = req_valid;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req (arb_req),
        .ptr (rr_ptr_q),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign can_accept = (state_q == ARB_IDLE) && !is_transmitting;
    assign req_ready  = can_accept ? win_gnt : '0;
    assign accept     = can_accept && (|arb_req);
    assign rr_next    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        start_err_c = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    tx_byte_d  = req_data[{win_idx, 3'b000} +: 8];
                    grant_id_d = win_idx;
                    state_d    = ARB_START;
`ifdef UART_TX_ARB_LOCK_EN
                    // Pointer only moves past a source once its message ends.
                    if (req_last[win_idx]) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = rr_next;
                    end else begin
                        lock_d   = 1'b1;
                    end
`else
                    rr_ptr_d   = rr_next;
`endif
                end
            end
            ARB_START: begin
                to_cnt_d = '0;
                state_d  = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (is_transmitting) begin
                    state_d = ARB_WAIT_DONE;
                end else if (to_cnt_q == TW'(START_TIMEOUT - 1)) begin
                    // UART never started: drop the byte, no retry.
                    start_err_c = 1'b1;
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ARB_WAIT_DONE: begin
                if (!is_transmitting) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
                end
            end
            ARB_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            tx_byte_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign transmit  = (state_q == ARB_START);
    assign tx_byte   = tx_byte_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != ARB_IDLE);
    assign start_err = start_err_c;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios for reset,
// single byte, round-robin, start timeout, mid-byte reset, inter-byte gap
// and (lock build) contiguous messages.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int FRAME = 20;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (GAP_CYCLES = 0) ----------------
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic           transmit;
    logic [7:0]     tx_byte;
    logic           is_transmitting = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;
    logic           start_err;
    logic [2:0]     state_dbg;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .START_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .transmit(transmit),
        .tx_byte(tx_byte), .is_transmitting(is_transmitting), .grant_id(grant_id),
        .busy(busy), .start_err(start_err), .state_dbg(state_dbg)
    );

    // ---------------- gap DUT (GAP_CYCLES = 5) ----------------
    logic [N-1:0]   g_valid = '0;
    logic [8*N-1:0] g_data  = {4{8'h47}};
    logic [N-1:0]   g_last  = '1;
    logic [N-1:0]   g_ready;
    logic           g_transmit;
    logic [7:0]     g_tx_byte;
    logic           g_istx = 1'b0;
    logic [1:0]     g_grant;
    logic           g_busy;
    logic           g_err;
    logic [2:0]     g_state;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(5), .START_TIMEOUT(16)) dut_g (
        .clk(clk), .reset_n(reset_n), .req_valid(g_valid), .req_data(g_data),
        .req_last(g_last), .req_ready(g_ready), .transmit(g_transmit),
        .tx_byte(g_tx_byte), .is_transmitting(g_istx), .grant_id(g_grant),
        .busy(g_busy), .start_err(g_err), .state_dbg(g_state)
    );

    // ---------------- UART models: busy 1 cycle after transmit, FRAME cycles ----------------
    logic dead = 1'b0;
    logic m_t, g_t;
    int   m_cnt = 0;
    int   g_cnt = 0;

    always @(posedge clk) begin
        m_t = transmit;
        #2;
        if (m_t && !dead) begin
            is_transmitting = 1'b1;
            m_cnt = FRAME;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) is_transmitting = 1'b0;
        end
    end

    always @(posedge clk) begin
        g_t = g_transmit;
        #2;
        if (g_t) begin
            g_istx = 1'b1;
            g_cnt = FRAME;
        end else if (g_cnt > 0) begin
            g_cnt--;
            if (g_cnt == 0) g_istx = 1'b0;
        end
    end

    // ---------------- source driver: per-requester byte sequences ----------------
    logic [7:0] seq [N][8];
    int         len [N];
    int         pos [N];
    bit         rep [N];
    logic [N-1:0] acc;

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            len[i] = 0;
            pos[i] = 0;
            rep[i] = 1'b0;
            for (int k = 0; k < 8; k++) seq[i][k] = 8'h00;
        end
    endtask

    always @(posedge clk) begin
        acc = req_valid & req_ready;
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                pos[i]++;
                if (rep[i] && pos[i] >= len[i]) pos[i] = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (pos[i] < len[i]);
            req_data[8*i +: 8] = seq[i][pos[i] % 8];
            req_last[i]        = (pos[i] == len[i] - 1);
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] obs_b [$];
    logic [1:0] obs_id [$];
    int         obs_cyc [$];
    int         err_cyc [$];
    int         cyc = 0;
    int         istx_fall = -1;
    int         busy_fall = -1;
    logic       prev_istx = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (transmit) begin
            obs_b.push_back(tx_byte);
            obs_id.push_back(grant_id);
            obs_cyc.push_back(cyc);
        end
        if (start_err) err_cyc.push_back(cyc);
        if (prev_istx && !is_transmitting) istx_fall = cyc;
        if (prev_busy && !busy) busy_fall = cyc;
        prev_istx = is_transmitting;
        prev_busy = busy;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    logic [1:0] exp_id [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_sb(input string tag);
        check_eq({tag, "_count"}, obs_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_b.size()) begin
                check_eq($sformatf("%s_byte%0d", tag, i), obs_b[i], exp_q[i]);
                check_eq($sformatf("%s_id%0d", tag, i), obs_id[i], exp_id[i]);
            end
        end
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic [1:0] id);
        exp_q.push_back(b);
        exp_id.push_back(id);
    endtask

    task automatic clear_logs();
        obs_b.delete();
        obs_id.delete();
        obs_cyc.delete();
        err_cyc.delete();
        exp_q.delete();
        exp_id.delete();
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (obs_b.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_wait_budget", (obs_b.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(state_dbg == 3'(ARB_IDLE) && !is_transmitting) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("idle_wait_budget", (k < budget), 1);
        @(negedge clk);
    endtask

    // Reset asserted with sources cleared; caller configures, then releases.
    task automatic enter_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_src();
        @(negedge clk);
        clear_logs();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    int k_wait;
    int viol;
    int gap_fall;
    int gap_rdy;
    logic g_prev;

    initial begin
        clear_src();
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_transmit", transmit, 0);
        check_eq("rst_tx_byte", tx_byte, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_start_err", start_err, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_busy", busy, 0);

        // Single requester 0 sends 72
        enter_reset();
        seq[0][0] = 8'd72; len[0] = 1;
        expect_byte(8'd72, 2'd0);
        release_reset();
        wait_tx(1, 60);
        wait_idle(60);
        check_sb("single");
        check_eq("single_busy_fall_delay", busy_fall - istx_fall, 1);
        check_eq("single_tx_byte_hold", tx_byte, 72);

        // All four valid: round-robin 65,66,67,68,65
        enter_reset();
        for (int i = 0; i < N; i++) begin
            seq[i][0] = 8'(65 + i);
            len[i] = 1;
            rep[i] = 1'b1;
        end
        expect_byte(8'd65, 2'd0);
        expect_byte(8'd66, 2'd1);
        expect_byte(8'd67, 2'd2);
        expect_byte(8'd68, 2'd3);
        expect_byte(8'd65, 2'd0);
        release_reset();
        wait_tx(5, 200);
        clear_src();
        wait_idle(60);
        check_sb("rr");

        // UART never goes busy: start_err 16 cycles after transmit, next request served
        enter_reset();
        dead = 1'b1;
        seq[0][0] = 8'h11; len[0] = 1;
        seq[1][0] = 8'h22; len[1] = 1;
        expect_byte(8'h11, 2'd0);
        expect_byte(8'h22, 2'd1);
        release_reset();
        wait_tx(2, 80);
        wait_idle(60);
        check_sb("timeout");
        check_eq("timeout_err_count", err_cyc.size(), 2);
        if (err_cyc.size() > 0 && obs_cyc.size() > 0)
            check_eq("timeout_err_delay", err_cyc[0] - obs_cyc[0], 16);
        dead = 1'b0;

        // Reset during WAIT_DONE
        enter_reset();
        seq[0][0] = 8'h55; len[0] = 1; rep[0] = 1'b1;
        release_reset();
        k_wait = 0;
        while (state_dbg != 3'(ARB_WAIT_DONE) && k_wait < 60) begin
            @(negedge clk);
            k_wait++;
        end
        check_eq("mid_reset_reached_wait_done", state_dbg, 3'(ARB_WAIT_DONE));
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset_transmit", transmit, 0);
        check_eq("mid_reset_busy", busy, 0);
        check_eq("mid_reset_tx_byte", tx_byte, 0);
        check_eq("mid_reset_grant_id", grant_id, 0);
        check_eq("mid_reset_req_ready", req_ready, 0);
        check_eq("mid_reset_start_err", start_err, 0);
        @(negedge clk);
        clear_logs();
        release_reset();
        viol = 0;
        k_wait = 0;
        while (is_transmitting && k_wait < 40) begin
            if (transmit || req_ready != '0 || busy) viol++;
            @(negedge clk);
            k_wait++;
        end
        check_eq("mid_reset_no_grant_while_uart_busy", viol, 0);
        check_eq("mid_reset_no_spurious_tx", obs_b.size(), 0);
        wait_tx(1, 40);
        if (obs_b.size() > 0) check_eq("mid_reset_reaccept_byte", obs_b[0], 8'h55);
        clear_src();
        wait_idle(60);

        // GAP_CYCLES = 5 on the second instance
        enter_reset();
        release_reset();
        g_valid = 4'b0001;
        gap_fall = -1;
        gap_rdy  = -1;
        g_prev   = g_istx;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (g_prev && !g_istx && gap_fall < 0) gap_fall = k;
            if (gap_fall >= 0 && g_ready != '0) begin
                gap_rdy = k;
                break;
            end
            g_prev = g_istx;
        end
        check_eq("gap_cycles", (gap_fall >= 0 && gap_rdy >= 0) ? gap_rdy - gap_fall - 1 : -1, 5);
        check_eq("gap_tx_byte", g_tx_byte, 8'h47);
        g_valid = '0;

`ifdef UART_TX_ARB_LOCK_EN
        // Locked message from requester 1 ahead of requester 2
        enter_reset();
        seq[1][0] = 8'd72; seq[1][1] = 8'd69; seq[1][2] = 8'd76; seq[1][3] = 8'd76;
        seq[1][4] = 8'd79; seq[1][5] = ASCII_CR; seq[1][6] = ASCII_LF;
        len[1] = 7;
        seq[2][0] = 8'd90; len[2] = 1;
        for (int i = 0; i < 7; i++) expect_byte(seq[1][i], 2'd1);
        expect_byte(8'd90, 2'd2);
        release_reset();
        wait_tx(8, 260);
        wait_idle(60);
        check_sb("lock");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
